seq_controller: RTL

Parametrised fetch/decode/execute sequencer that drives an ALU-style datapath from a synchronous instruction memory. It steps a program counter, splits each instruction into opcode and two operands, and launches the datapath with a start/done handshake. Compared with the first-generation controller it adds:
- generic operand, opcode and address widths
- a jump opcode
- an abort input
- a datapath watchdog timeout
- a distinct ERROR state with sticky flags

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_watchdog.sv | 32 +++
 rtl/seq_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and opcode helpers for the fetch/decode/execute sequencer.
package ctrl_pkg;

  // Controller state; also exported on the debug port of seq_controller.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // HALT is the all-ones opcode for the given opcode width.
  function automatic int halt_code(input int op_w);
    return (1 << op_w) - 1;
  endfunction

  // JMP sits just below HALT.
  function automatic int jmp_code(input int op_w);
    return halt_code(op_w) - 1;
  endfunction

  // Instruction word is {opcode, a, b}.
  function automatic int instr_width(input int op_w, input int data_w);
    return op_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Cycle counter that flags when an EXEC phase has lasted TIMEOUT cycles.
// The count reads 0 in the first counted cycle and expired is high while
// the count equals TIMEOUT-1.
module ctrl_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count up while enabled; clear has priority so the next EXEC starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/seq_controller.sv
// Fetch/decode/execute sequencer driving an ALU-style datapath from a
// synchronous (1-cycle read latency) instruction memory.
//
// Datapath handshake: start is a one-cycle pulse in the first EXEC cycle;
// enable is high for every EXEC cycle; the datapath answers with done,
// which is only looked at in EXEC (done in the start cycle is a legal
// single-cycle op). Leaving EXEC for any reason (done, watchdog, abort,
// reset) drops enable in the next cycle, so the datapath must tolerate
// an op being abandoned.
//
// The JMP target is taken from the low ADDR_W bits of operand a, so
// ADDR_W must not exceed DATA_W.
module seq_controller
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int ADDR_W  = 5,
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 16,
  localparam int INSTR_W = instr_width(OP_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  input  logic [INSTR_W-1:0] instr,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               start,
  output logic               enable,
  output logic [OP_W-1:0]    opcode,
  output logic [DATA_W-1:0]  a,
  output logic [DATA_W-1:0]  b,
  output logic               busy,
  output logic               halted,
  output logic               invalid_opcode,
  output logic               timeout,
  output state_t             state
);

  localparam logic [OP_W-1:0] HALT_OP = OP_W'(halt_code(OP_W));
  localparam logic [OP_W-1:0] JMP_OP  = OP_W'(jmp_code(OP_W));
  localparam logic [OP_W-1:0] OPS_LIM = OP_W'(NUM_OPS);

  state_t state_q;
  state_t state_next;

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic              wd_clear;
  logic              wd_count_en;
  logic              wd_expired;

  assign dec_op = instr[INSTR_W-1 -: OP_W];
  assign dec_a  = instr[2*DATA_W-1 -: DATA_W];
  assign dec_b  = instr[DATA_W-1:0];

  // Watchdog only runs while staying in EXEC; everything else holds it at 0.
  assign wd_count_en = (state_q == EXEC);
  assign wd_clear    = (state_q != EXEC) || (state_next != EXEC);

  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE, ERROR: begin
        if (go) state_next = FETCH;
      end
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        if (dec_op == HALT_OP)     state_next = IDLE;
        else if (dec_op == JMP_OP) state_next = FETCH;
        else if (dec_op < OPS_LIM) state_next = EXEC;
        else                       state_next = ERROR;
      end
      EXEC: begin
        if (done)            state_next = FETCH;
        else if (wd_expired) state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort) state_next = IDLE;
  end

  // Program counter, latched instruction fields, start pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= '0;
      opcode         <= '0;
      a              <= '0;
      b              <= '0;
      start          <= 1'b0;
      halted         <= 1'b0;
      invalid_opcode <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      start <= (state_q == DECODE) && (state_next == EXEC);
      if (!abort) begin
        case (state_q)
          IDLE, ERROR: begin
            if (go) begin
              pc             <= '0;
              halted         <= 1'b0;
              invalid_opcode <= 1'b0;
              timeout        <= 1'b0;
            end
          end
          DECODE: begin
            opcode <= dec_op;
            a      <= dec_a;
            b      <= dec_b;
            if (dec_op == HALT_OP)      halted         <= 1'b1;
            else if (dec_op == JMP_OP)  pc             <= dec_a[ADDR_W-1:0];
            else if (dec_op >= OPS_LIM) invalid_opcode <= 1'b1;
          end
          EXEC: begin
            if (done)            pc      <= pc + ADDR_W'(1);
            else if (wd_expired) timeout <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign enable = (state_q == EXEC);
  assign busy   = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
  assign state  = state_q;

endmodule
